axi_lite_arbiter: RTL and testbench



---
 rtl/axi_lite_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_arbiter.sv
// Two-master AXI-lite arbiter: IFU (m0, read-only) and LSU (m1, read/write) share one slave port.
// One transaction at a time, round-robin on contention, grant held from address through response.
//
// state | meaning
// IDLE  | no grant; nothing forwarded, arbitration happens here
// M0_RD | m0 owns AR/R
// M1_RD | m1 owns AR/R
// M1_WR | m1 owns AW/W/B
module axi_lite_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_W-1:0]     m0_araddr,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,

    input  logic [ADDR_W-1:0]     m1_araddr,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    input  logic [ADDR_W-1:0]     m1_awaddr,
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    input  logic                  m1_wvalid,
    output logic                  m1_wready,
    output logic [1:0]            m1_bresp,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,

    output logic [ADDR_W-1:0]     s_araddr,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    input  logic [1:0]            s_bresp,
    input  logic                  s_bvalid,
    output logic                  s_bready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        M0_RD = 2'd1,
        M1_RD = 2'd2,
        M1_WR = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   last_grant, last_grant_nxt;
    logic   ar_done, aw_done, w_done;
    logic   ar_hs, aw_hs, w_hs;

    logic req0, req1w, req1r, m1_turn;

    assign req0    = m0_arvalid;
    assign req1w   = m1_awvalid & m1_wvalid;
    assign req1r   = m1_arvalid & ~req1w;
    // m1 loses only when m0 is also asking and m1 had the previous grant
    assign m1_turn = ~(req0 & last_grant);

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        ar_hs          = 1'b0;
        aw_hs          = 1'b0;
        w_hs           = 1'b0;

        m0_arready = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = 2'b00;
        m0_rvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = 2'b00;
        m1_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bresp   = 2'b00;
        m1_bvalid  = 1'b0;

        s_araddr   = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        s_awaddr   = '0;
        s_awvalid  = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;

        case (state)
            IDLE: begin
                if (req1w && m1_turn) begin
                    state_nxt      = M1_WR;
                    last_grant_nxt = 1'b1;
                end else if (req1r && m1_turn) begin
                    state_nxt      = M1_RD;
                    last_grant_nxt = 1'b1;
                end else if (req0) begin
                    state_nxt      = M0_RD;
                    last_grant_nxt = 1'b0;
                end
            end

            M0_RD: begin
                s_araddr   = m0_araddr;
                s_arvalid  = m0_arvalid & ~ar_done;
                m0_arready = s_arready & ~ar_done;
                ar_hs      = m0_arvalid & s_arready & ~ar_done;
                m0_rdata   = s_rdata;
                m0_rresp   = s_rresp;
                m0_rvalid  = s_rvalid;
                s_rready   = m0_rready;
                if (s_rvalid && m0_rready) begin
                    state_nxt = IDLE;
                end
            end

            M1_RD: begin
                s_araddr   = m1_araddr;
                s_arvalid  = m1_arvalid & ~ar_done;
                m1_arready = s_arready & ~ar_done;
                ar_hs      = m1_arvalid & s_arready & ~ar_done;
                m1_rdata   = s_rdata;
                m1_rresp   = s_rresp;
                m1_rvalid  = s_rvalid;
                s_rready   = m1_rready;
                if (s_rvalid && m1_rready) begin
                    state_nxt = IDLE;
                end
            end

            M1_WR: begin
                // AW and W complete independently, in either order or together
                s_awaddr   = m1_awaddr;
                s_awvalid  = m1_awvalid & ~aw_done;
                m1_awready = s_awready & ~aw_done;
                aw_hs      = m1_awvalid & s_awready & ~aw_done;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                s_wvalid   = m1_wvalid & ~w_done;
                m1_wready  = s_wready & ~w_done;
                w_hs       = m1_wvalid & s_wready & ~w_done;
                m1_bresp   = s_bresp;
                m1_bvalid  = s_bvalid;
                s_bready   = m1_bready;
                if (s_bvalid && m1_bready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            ar_done    <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            if (state_nxt == IDLE) begin
                ar_done <= 1'b0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                ar_done <= ar_done | ar_hs;
                aw_done <= aw_done | aw_hs;
                w_done  <= w_done | w_hs;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: a transaction-level ownership model is compared
// against every output on each falling edge, plus literal expectations per scenario.
module tb_axi_lite_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata, s_rdata;
    logic [3:0]  m1_wstrb;
    logic [1:0]  s_rresp, s_bresp;
    logic m0_arvalid, m0_rready, m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bready;
    logic s_arready, s_rvalid, s_awready, s_wready, s_bvalid;

    logic [31:0] s_araddr, s_awaddr, s_wdata, m0_rdata, m1_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  m0_rresp, m1_rresp, m1_bresp;
    logic s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid;

    axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    typedef struct packed {
        logic [31:0] s_araddr;  logic s_arvalid; logic s_rready;
        logic [31:0] s_awaddr;  logic s_awvalid;
        logic [31:0] s_wdata;   logic [3:0] s_wstrb; logic s_wvalid; logic s_bready;
        logic m0_arready; logic [31:0] m0_rdata; logic [1:0] m0_rresp; logic m0_rvalid;
        logic m1_arready; logic [31:0] m1_rdata; logic [1:0] m1_rresp; logic m1_rvalid;
        logic m1_awready; logic m1_wready; logic [1:0] m1_bresp; logic m1_bvalid;
    } outs_t;

    outs_t act;
    assign act = {s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb,
                  s_wvalid, s_bready, m0_arready, m0_rdata, m0_rresp, m0_rvalid,
                  m1_arready, m1_rdata, m1_rresp, m1_rvalid, m1_awready, m1_wready,
                  m1_bresp, m1_bvalid};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Transaction-level model: who owns the slave, and whether its address/data beats went out
    localparam int NONE = 0, OWN_M0 = 1, OWN_M1R = 2, OWN_M1W = 3;
    int owner = NONE;
    bit addr_sent = 1'b0;
    bit data_sent = 1'b0;
    bit prev_m1 = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= NONE;
            addr_sent <= 1'b0;
            data_sent <= 1'b0;
            prev_m1   <= 1'b0;
        end else if (owner == NONE) begin
            if (m1_awvalid && m1_wvalid && !(m0_arvalid && prev_m1)) begin
                owner <= OWN_M1W; prev_m1 <= 1'b1;
            end else if (m1_arvalid && !(m0_arvalid && prev_m1)) begin
                owner <= OWN_M1R; prev_m1 <= 1'b1;
            end else if (m0_arvalid) begin
                owner <= OWN_M0; prev_m1 <= 1'b0;
            end
        end else if (owner == OWN_M1W) begin
            if (s_bvalid && m1_bready) begin
                owner <= NONE; addr_sent <= 1'b0; data_sent <= 1'b0;
            end else begin
                if (m1_awvalid && s_awready) addr_sent <= 1'b1;
                if (m1_wvalid && s_wready) data_sent <= 1'b1;
            end
        end else begin
            if (s_rvalid && (owner == OWN_M0 ? m0_rready : m1_rready)) begin
                owner <= NONE; addr_sent <= 1'b0;
            end else if ((owner == OWN_M0 ? m0_arvalid : m1_arvalid) && s_arready) begin
                addr_sent <= 1'b1;
            end
        end
    end

    function automatic outs_t model_out();
        outs_t e;
        e = '0;
        if (owner == OWN_M0 || owner == OWN_M1R) begin
            e.s_araddr  = (owner == OWN_M0) ? m0_araddr : m1_araddr;
            e.s_arvalid = ((owner == OWN_M0) ? m0_arvalid : m1_arvalid) && !addr_sent;
            e.s_rready  = (owner == OWN_M0) ? m0_rready : m1_rready;
            if (owner == OWN_M0) begin
                e.m0_arready = s_arready && !addr_sent;
                e.m0_rdata = s_rdata; e.m0_rresp = s_rresp; e.m0_rvalid = s_rvalid;
            end else begin
                e.m1_arready = s_arready && !addr_sent;
                e.m1_rdata = s_rdata; e.m1_rresp = s_rresp; e.m1_rvalid = s_rvalid;
            end
        end else if (owner == OWN_M1W) begin
            e.s_awaddr   = m1_awaddr;
            e.s_awvalid  = m1_awvalid && !addr_sent;
            e.m1_awready = s_awready && !addr_sent;
            e.s_wdata    = m1_wdata;
            e.s_wstrb    = m1_wstrb;
            e.s_wvalid   = m1_wvalid && !data_sent;
            e.m1_wready  = s_wready && !data_sent;
            e.s_bready   = m1_bready;
            e.m1_bresp   = s_bresp;
            e.m1_bvalid  = s_bvalid;
        end
        return e;
    endfunction

    outs_t exp_o;
    initial begin
        forever begin
            @(negedge clk);
            exp_o = model_out();
            chk("s_araddr",   64'(act.s_araddr),   64'(exp_o.s_araddr));
            chk("s_arvalid",  64'(act.s_arvalid),  64'(exp_o.s_arvalid));
            chk("s_rready",   64'(act.s_rready),   64'(exp_o.s_rready));
            chk("s_awaddr",   64'(act.s_awaddr),   64'(exp_o.s_awaddr));
            chk("s_awvalid",  64'(act.s_awvalid),  64'(exp_o.s_awvalid));
            chk("s_wdata",    64'(act.s_wdata),    64'(exp_o.s_wdata));
            chk("s_wstrb",    64'(act.s_wstrb),    64'(exp_o.s_wstrb));
            chk("s_wvalid",   64'(act.s_wvalid),   64'(exp_o.s_wvalid));
            chk("s_bready",   64'(act.s_bready),   64'(exp_o.s_bready));
            chk("m0_arready", 64'(act.m0_arready), 64'(exp_o.m0_arready));
            chk("m0_rdata",   64'(act.m0_rdata),   64'(exp_o.m0_rdata));
            chk("m0_rresp",   64'(act.m0_rresp),   64'(exp_o.m0_rresp));
            chk("m0_rvalid",  64'(act.m0_rvalid),  64'(exp_o.m0_rvalid));
            chk("m1_arready", 64'(act.m1_arready), 64'(exp_o.m1_arready));
            chk("m1_rdata",   64'(act.m1_rdata),   64'(exp_o.m1_rdata));
            chk("m1_rresp",   64'(act.m1_rresp),   64'(exp_o.m1_rresp));
            chk("m1_rvalid",  64'(act.m1_rvalid),  64'(exp_o.m1_rvalid));
            chk("m1_awready", 64'(act.m1_awready), 64'(exp_o.m1_awready));
            chk("m1_wready",  64'(act.m1_wready),  64'(exp_o.m1_wready));
            chk("m1_bresp",   64'(act.m1_bresp),   64'(exp_o.m1_bresp));
            chk("m1_bvalid",  64'(act.m1_bvalid),  64'(exp_o.m1_bvalid));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        m0_araddr = '0; m0_arvalid = 0; m0_rready = 0;
        m1_araddr = '0; m1_arvalid = 0; m1_rready = 0;
        m1_awaddr = '0; m1_awvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0; m1_bready = 0;
        s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
        s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;

        repeat (2) @(posedge clk);
        #2 chk("reset_all_zero", 64'(|act), 64'd0);
        @(negedge clk) rst = 1'b0;

        // m0 read alone
        tick(); m0_araddr = 32'h8000_0000; m0_arvalid = 1; m0_rready = 1; s_arready = 1;
        #1 chk("t1_idle_no_arvalid", 64'(s_arvalid), 64'd0);
        tick(); #1 chk("t1_s_arvalid", 64'(s_arvalid), 64'd1);
        chk("t1_s_araddr", 64'(s_araddr), 64'h8000_0000);
        tick(); m0_arvalid = 0; #1 chk("t1_ar_done", 64'(s_arvalid), 64'd0);
        tick(); s_rvalid = 1; s_rdata = 32'h0000_0413; s_rresp = 2'b00;
        #1 chk("t1_m0_rvalid", 64'(m0_rvalid), 64'd1);
        chk("t1_m0_rdata", 64'(m0_rdata), 64'h413);
        chk("t1_m0_rresp", 64'(m0_rresp), 64'd0);
        tick(); s_rvalid = 0; s_rdata = '0;
        #1 chk("t1_back_idle", 64'(s_rready), 64'd0);

        // contest from reset history: m1 first, then m0, then m1 again
        tick(); m0_araddr = 32'h8000_0004; m0_arvalid = 1;
        m1_araddr = 32'h9000_0000; m1_arvalid = 1; m1_rready = 1;
        #1 chk("t2_idle_m1_arready", 64'(m1_arready), 64'd0);
        tick(); #1 chk("t2_m1_granted", 64'(m1_arready), 64'd1);
        chk("t2_m0_waits", 64'(m0_arready), 64'd0);
        chk("t2_s_araddr", 64'(s_araddr), 64'h9000_0000);
        tick(); s_rvalid = 1; s_rdata = 32'h1111_1111;
        #1 chk("t2_m1_rdata", 64'(m1_rdata), 64'h1111_1111);
        chk("t2_m0_no_rvalid", 64'(m0_rvalid), 64'd0);
        tick(); s_rvalid = 0;
        #1 chk("t2_gap_m0", 64'(m0_arready), 64'd0);
        chk("t2_gap_m1", 64'(m1_arready), 64'd0);
        tick(); #1 chk("t2_m0_granted", 64'(m0_arready), 64'd1);
        chk("t2_m1_waits", 64'(m1_arready), 64'd0);
        tick(); m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'h2222_2222;
        #1 chk("t2_m0_rdata", 64'(m0_rdata), 64'h2222_2222);
        tick(); s_rvalid = 0;
        tick(); #1 chk("t2_m1_second", 64'(m1_arready), 64'd1);
        tick(); m1_arvalid = 0; s_rvalid = 1; s_rdata = 32'h3333_3333;
        #1 chk("t2_m1_rvalid", 64'(m1_rvalid), 64'd1);
        tick(); s_rvalid = 0;

        // m1 write with staggered slave readies; m0 arrives mid-write and stalls
        tick(); m1_awaddr = 32'h8000_0100; m1_awvalid = 1; m1_wdata = 32'hDEAD_BEEF;
        m1_wstrb = 4'hF; m1_wvalid = 1; m1_bready = 1;
        #1 chk("t3_idle_awvalid", 64'(s_awvalid), 64'd0);
        tick(); m0_araddr = 32'h8000_0008; m0_arvalid = 1;
        #1 chk("t3_c0_awvalid", 64'(s_awvalid), 64'd1);
        chk("t3_c0_awaddr", 64'(s_awaddr), 64'h8000_0100);
        chk("t3_c0_wvalid", 64'(s_wvalid), 64'd1);
        chk("t3_c0_m0_stall", 64'(m0_arready), 64'd0);
        tick(); s_awready = 1;
        #1 chk("t3_c1_awready", 64'(m1_awready), 64'd1);
        tick(); s_awready = 0; m1_awvalid = 0;
        #1 chk("t3_c2_aw_dropped", 64'(s_awvalid), 64'd0);
        chk("t3_c2_w_held", 64'(s_wvalid), 64'd1);
        tick(); s_wready = 1;
        #1 chk("t3_c3_wready", 64'(m1_wready), 64'd1);
        chk("t3_c3_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
        chk("t3_c3_wstrb", 64'(s_wstrb), 64'hF);
        tick(); s_wready = 0; m1_wvalid = 0; s_bvalid = 1; s_bresp = 2'b00;
        #1 chk("t3_c4_bvalid", 64'(m1_bvalid), 64'd1);
        chk("t3_c4_m0_stall", 64'(m0_arready), 64'd0);
        tick(); s_bvalid = 0;
        #1 chk("t3_idle_m0_stall", 64'(m0_arready), 64'd0);
        tick(); #1 chk("t3_m0_granted", 64'(m0_arready), 64'd1);
        tick(); m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'h4444_4444;
        tick(); s_rvalid = 0;

        // write and read together: write first; SLVERR on the read passes through
        tick(); m1_awaddr = 32'h8000_0104; m1_awvalid = 1; m1_wvalid = 1; m1_wdata = 32'h1234_5678;
        m1_araddr = 32'h9000_0010; m1_arvalid = 1; s_awready = 1; s_wready = 1;
        #1 chk("t4_idle_arvalid", 64'(s_arvalid), 64'd0);
        tick(); #1 chk("t4_write_first", 64'(s_awvalid), 64'd1);
        chk("t4_read_held", 64'(s_arvalid), 64'd0);
        tick(); m1_awvalid = 0; m1_wvalid = 0; s_bvalid = 1;
        #1 chk("t4_aw_w_done", 64'({s_awvalid, s_wvalid}), 64'd0);
        chk("t4_bvalid", 64'(m1_bvalid), 64'd1);
        tick(); s_bvalid = 0; s_awready = 0; s_wready = 0;
        #1 chk("t4_gap", 64'(m1_arready), 64'd0);
        tick(); #1 chk("t4_read_granted", 64'(m1_arready), 64'd1);
        chk("t4_read_addr", 64'(s_araddr), 64'h9000_0010);
        tick(); m1_arvalid = 0; s_rvalid = 1; s_rresp = 2'b10; s_rdata = 32'h0000_0BAD;
        #1 chk("t5_rresp_slverr", 64'(m1_rresp), 64'd2);
        chk("t5_rvalid", 64'(m1_rvalid), 64'd1);
        tick(); s_rvalid = 0; s_rresp = 2'b00;
        tick(); m0_arvalid = 1; m0_araddr = 32'h8000_000C;
        tick(); #1 chk("t5_released_m0", 64'(m0_arready), 64'd1);
        tick(); m0_arvalid = 0; s_rvalid = 1;
        tick(); s_rvalid = 0;

        // asynchronous reset after AW accepted
        tick(); m1_awaddr = 32'h8000_0200; m1_awvalid = 1; m1_wvalid = 1; m1_wdata = 32'hCAFE_F00D;
        s_awready = 1; s_wready = 0;
        tick();
        tick(); m1_awvalid = 0;
        #1 chk("t6_aw_accepted", 64'(s_awvalid), 64'd0);
        chk("t6_w_pending", 64'(s_wvalid), 64'd1);
        rst = 1'b1; m1_wvalid = 0; s_awready = 0;
        #1 chk("t6_reset_zero", 64'(|act), 64'd0);
        @(negedge clk) rst = 1'b0;
        tick(); s_bvalid = 1;
        #1 chk("t6_b_not_forwarded", 64'(m1_bvalid), 64'd0);
        chk("t6_bready_low", 64'(s_bready), 64'd0);
        tick(); s_bvalid = 0; m0_arvalid = 1; m0_araddr = 32'h8000_0010;
        #1 chk("t6_idle_m0", 64'(m0_arready), 64'd0);
        tick(); #1 chk("t6_m0_granted", 64'(m0_arready), 64'd1);
        tick(); m0_arvalid = 0; s_rvalid = 1;
        tick(); s_rvalid = 0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
